abc_truth_sampler: RTL and testbench

Sequential stimulus and capture stage for the 3-input combinational function block. On a start pulse it drives the eight input combinations onto A, B, C in ascending order, holds each for a programmable dwell time, samples the function output F at the end of each dwell, and assembles the results into an 8-bit truth-table word. It replaces free-running `initial`-block stimulus with a synthesizable, handshaked source/sink, so the function block can be exercised on the board as well as in simulation.

---
 rtl/abc_pkg.sv | 30 +++
 rtl/dwell_timer.sv | 28 ++
 rtl/abc_truth_sampler.sv | 119 +++++++++++
 tb/tb_abc_truth_sampler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/abc_pkg.sv
// Shared types and constants for the truth-table sampler.
package abc_pkg;

  localparam int N_VEC     = 8;    // number of input combinations
  localparam int IDX_W     = 3;    // width of the vector index
  localparam int DWELL_MAX = 255;  // largest dwell the 8-bit timer can count
  localparam int CNT_W     = 8;    // dwell timer width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
  } abc_t;

  // A is the MSB of the index, C the LSB.
  function automatic abc_t idx_to_abc(input logic [IDX_W-1:0] idx);
    abc_t v;
    v.a = idx[2];
    v.b = idx[1];
    v.c = idx[0];
    return v;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, wrapping on terminal count.
module dwell_timer
  import abc_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal count marks the last cycle of a dwell.
  assign tc = (r_cnt == LAST);

  // Clear wins over enable; wrap to zero on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (en)     r_cnt <= tc ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/abc_truth_sampler.sv
// Sweeps the eight A/B/C combinations, samples F after each dwell and
// assembles the 8-bit truth table.
module abc_truth_sampler
  import abc_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             f_in,
  output logic [IDX_W-1:0] vec_idx,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_q,
  output logic             table_valid
);

  if (DWELL < 2 || DWELL > DWELL_MAX) begin : g_bad_dwell
    $error("abc_truth_sampler: DWELL must be in 2..255");
  end

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [N_VEC-1:0] r_table;
  logic             r_busy;
  logic             r_done;
  logic             r_tv;

  logic             w_accept;
  logic             w_clear;
  logic             w_en;
  logic             w_tc;
  abc_t             w_abc;

  // abort beats start in IDLE, so a simultaneous pair never launches a sweep.
  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_clear  = abort || w_accept;
  assign w_en     = (r_state == ST_DRIVE);

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .en    (w_en),
    .tc    (w_tc)
  );

  // Sweep control: state, vector index, capture and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        // Captured bits are kept so a partial sweep can still be inspected.
        r_state <= ST_IDLE;
        r_idx   <= '0;
        r_busy  <= 1'b0;
        r_tv    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_DRIVE;
              r_idx   <= '0;
              r_table <= '0;
              r_tv    <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          ST_DRIVE: begin
            if (w_tc) begin
              r_table[r_idx] <= f_in;
              if (r_idx == IDX_W'(N_VEC - 1)) begin
                // done and table_valid rise together for the DONE cycle.
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_tv    <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_abc       = idx_to_abc(r_idx);
  assign A           = w_abc.a;
  assign B           = w_abc.b;
  assign C           = w_abc.c;
  assign vec_idx     = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign table_q     = r_table;
  assign table_valid = r_tv;

endmodule

// File: tb/tb_abc_truth_sampler.sv
// Directed bench for abc_truth_sampler: DWELL=4 with a function model,
// DWELL=2 with F tied high.
module tb_abc_truth_sampler;

  logic       clk;
  logic       rst_n;
  // DWELL=4 instance
  logic       start, abort, f_in;
  logic       A, B, C, busy, done, table_valid;
  logic [2:0] vec_idx;
  logic [7:0] table_q;
  // DWELL=2 instance
  logic       start2, abort2, f_in2;
  logic       A2, B2, C2, busy2, done2, table_valid2;
  logic [2:0] vec_idx2;
  logic [7:0] table_q2;

  logic [7:0] model_f;
  int         checks;
  int         errors;

  abc_truth_sampler #(.DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .A(A), .B(B), .C(C), .f_in(f_in), .vec_idx(vec_idx),
    .busy(busy), .done(done), .table_q(table_q), .table_valid(table_valid)
  );

  abc_truth_sampler #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .A(A2), .B(B2), .C(C2), .f_in(f_in2), .vec_idx(vec_idx2),
    .busy(busy2), .done(done2), .table_q(table_q2), .table_valid(table_valid2)
  );

  // Reference function: F = 1 at idx 0, 2, 6.
  assign f_in  = model_f[vec_idx];
  assign f_in2 = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a DWELL=4 sweep; extra start pulses during cycles s1/s2.
  // Returns first and last done cycle, done count, and table at first done.
  task automatic sweep4(input int s1, input int s2, input int ncyc,
                        output int dfirst, output int dlast, output int ndone,
                        output logic [7:0] tq, output logic tv);
    dfirst = -1; dlast = -1; ndone = 0; tq = '0; tv = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == s1) || (c == s2);
      if (done) begin
        ndone++;
        dlast = c;
        if (dfirst < 0) begin
          dfirst = c;
          tq = table_q;
          tv = table_valid;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int         d1, d2, nd;
    logic [7:0] tq;
    logic       tv;
    logic [2:0] e;
    checks = 0; errors = 0;
    model_f = 8'h45;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_table", 32'(table_q), 0);
    chk("rst_tv",    32'(table_valid), 0);
    chk("rst_abc",   32'({vec_idx, A, B, C}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sweep with model function
    sweep4(0, 0, 40, d1, d2, nd, tq, tv);
    chk("s1_done_cyc", 32'(d1), 33);
    chk("s1_ndone",    32'(nd), 1);
    chk("s1_table",    32'(tq), 32'h45);
    chk("s1_tv",       32'(tv), 1);
    chk("s1_idle_busy",32'(busy), 0);
    chk("s1_tv_hold",  32'(table_valid), 1);

    // Extra start pulses mid-sweep are ignored
    sweep4(5, 20, 40, d1, d2, nd, tq, tv);
    chk("ign_done_cyc", 32'(d1), 33);
    chk("ign_ndone",    32'(nd), 1);
    chk("ign_table",    32'(tq), 32'h45);

    // Back-to-back: start in the IDLE cycle right after done
    sweep4(34, 0, 80, d1, d2, nd, tq, tv);
    chk("b2b_first", 32'(d1), 33);
    chk("b2b_second",32'(d2), 67);
    chk("b2b_ndone", 32'(nd), 2);

    // DWELL=2, F tied high: vector sequence and completion
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    d1 = -1;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 16) begin
        e = 3'((c - 1) / 2);
        chk("d2_vec", 32'({vec_idx2, A2, B2, C2}), 32'({e, e}));
      end
      if (done2 && d1 < 0) begin
        d1 = c;
        tq = table_q2;
      end
    end
    chk("d2_done_cyc", 32'(d1), 17);
    chk("d2_table",    32'(tq), 32'hFF);
    chk("d2_tv",       32'(table_valid2), 1);

    // Abort in cycle 14 (idx 3, three captures)
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    chk("ab_pre_idx",   32'(vec_idx), 3);
    chk("ab_pre_table", 32'(table_q), 32'h05);
    chk("ab_pre_tv",    32'(table_valid), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("ab_busy",  32'(busy), 0);
    chk("ab_table", 32'(table_q), 32'h05);
    chk("ab_tv",    32'(table_valid), 0);
    chk("ab_abc",   32'({vec_idx, A, B, C}), 0);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ab_no_done", 32'(nd), 0);
    sweep4(0, 0, 40, d1, d2, nd, tq, tv);
    chk("ab_rerun_table", 32'(tq), 32'h45);
    chk("ab_rerun_cyc",   32'(d1), 33);

    // Async reset in cycle 10
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rs_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy",  32'(busy), 0);
    chk("rs_table", 32'(table_q), 0);
    chk("rs_tv",    32'(table_valid), 0);
    chk("rs_abc",   32'({vec_idx, A, B, C}), 0);
    chk("rs_done",  32'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    sweep4(0, 0, 40, d1, d2, nd, tq, tv);
    chk("rs_rerun_cyc",   32'(d1), 33);
    chk("rs_rerun_table", 32'(tq), 32'h45);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 0);
    chk("sa_tv",   32'(table_valid), 0);
    repeat (3) @(negedge clk);
    chk("sa_busy_late", 32'(busy), 0);
    chk("sa_idx",       32'(vec_idx), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
